mux3: RTL and testbench
=======================

MUX3 -- requirements
Module: mux3

Interface
REQ-001 Parameter WIDTH, default 32: bit width of d0, d1, d2, y and y_q.
REQ-002 Parameter CNT_W, default 8: bit width of err_cnt.
REQ-003 clk  input  1  single clock; all registers update on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 d0  input  WIDTH  data input selected when sel=2'b00.
REQ-006 d1  input  WIDTH  data input selected when sel=2'b01.
REQ-007 d2  input  WIDTH  data input selected when sel=2'b10.
REQ-008 sel  input  2  select code.
REQ-009 y  output  WIDTH  combinational mux result.
REQ-010 y_q  output  WIDTH  registered copy of y.
REQ-011 sel_err  output  1  combinational flag, high while sel=2'b11.
REQ-012 err_cnt  output  CNT_W  saturating count of clock edges sampled with sel=2'b11.

Function
REQ-013 y SHALL equal d0 when sel=00, d1 when sel=01 and d2 when sel=10, with zero clock latency (purely combinational).
REQ-014 For sel=2'b11, y SHALL be all zeros, never X or a data input.
REQ-015 y SHALL respond within the same delta cycle to any change on d0, d1, d2 or sel, without depending on clk or reset.
REQ-016 sel_err SHALL be 1 exactly when sel=2'b11 and 0 otherwise, combinationally.
REQ-017 On each rising clk edge with reset low, y_q SHALL load the value y had before the edge (one-cycle latency).
REQ-018 On each rising clk edge with reset low and sel=2'b11, err_cnt SHALL increment by 1.
REQ-019 err_cnt SHALL saturate at 2^CNT_W-1 and SHALL NOT wrap to zero.
REQ-020 When sel is not 2'b11 at a clock edge, err_cnt SHALL hold its value.
REQ-021 Any X or Z bit on sel SHALL cause y=0 and sel_err=0 in synthesis semantics; the bench does not drive X on sel.
REQ-022 Data inputs SHALL be passed through unmodified, with no sign extension, truncation or inversion.

Reset
REQ-023 While reset is high, y_q SHALL be 0 and err_cnt SHALL be 0, immediately and without waiting for a clock edge.
REQ-024 Reset SHALL NOT affect y or sel_err; these remain combinational functions of their inputs during reset.
REQ-025 Deassertion of reset SHALL take effect at the next rising clk edge; no register updates on the edge where reset is still high.
REQ-026 Assertion of reset during operation SHALL clear y_q and err_cnt asynchronously, including a saturated err_cnt.

Verification
REQ-027 d0=37b83cf9, d1=f3dc719f, d2=e75b262d; step sel 00/01/10/11 every 10 ns. Required: y=37b83cf9, f3dc719f, e75b262d, 00000000; sel_err is high only for sel=11.
REQ-028 d0=6420271d, d1=030ceb69, d2=f707ce7e; same sel sweep. Required: y=6420271d, 030ceb69, f707ce7e, 0.
REQ-029 d0=5cc0bf9c, d1=c6da743d, d2=75c816b7; same sel sweep with clk running and reset released. Required: y_q equals the previous-cycle y at every edge.
REQ-030 Hold sel=11 for 300 clock edges with CNT_W=8. Required: err_cnt reaches 255 and stays at 255.
REQ-031 Assert reset mid-cycle while err_cnt=255 and y_q is nonzero. Required: both outputs are 0 immediately, and y still tracks sel.
REQ-032 Change d1 while sel=01 with no clock edge. Required: y follows d1 immediately and y_q keeps its old value until the next edge.

Source files
------------

// File: rtl/mux3.sv
// Three-input data mux with a registered copy of the result.
// A saturating counter records clock edges that see the invalid select 2'b11.
module mux3 #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d0,
  input  logic [WIDTH-1:0] d1,
  input  logic [WIDTH-1:0] d2,
  input  logic [1:0]       sel,
  output logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] y_q,
  output logic             sel_err,
  output logic [CNT_W-1:0] err_cnt
);

  logic [WIDTH-1:0] y_d;
  logic [WIDTH-1:0] y_q_d;
  logic             sel_err_d;
  logic [CNT_W-1:0] err_cnt_d;
  logic [CNT_W-1:0] err_cnt_q;

  // Select decode; the invalid code and any unknown select give zero
  always_comb begin
    y_d       = '0;
    sel_err_d = 1'b0;
    case (sel)
      2'b00:   y_d = d0;
      2'b01:   y_d = d1;
      2'b10:   y_d = d2;
      2'b11:   sel_err_d = 1'b1;
      default: y_d = '0;
    endcase
  end

  assign y       = y_d;
  assign sel_err = sel_err_d;

  // Next-state: follow y, count invalid selects until all ones
  always_comb begin
    y_q_d     = y_d;
    err_cnt_d = err_cnt_q;
    if (sel_err_d && (err_cnt_q != {CNT_W{1'b1}})) begin
      err_cnt_d = err_cnt_q + CNT_W'(1);
    end
  end

  // Registers cleared asynchronously while reset is high
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      y_q       <= '0;
      err_cnt_q <= '0;
    end else begin
      y_q       <= y_q_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign err_cnt = err_cnt_q;

endmodule

// File: tb/tb_mux3.sv
// Directed bench for mux3: select sweeps, registered copy,
// counter saturation and asynchronous reset behaviour.
module tb_mux3;

  logic        clk;
  logic        reset;
  logic [31:0] d0;
  logic [31:0] d1;
  logic [31:0] d2;
  logic [1:0]  sel;
  logic [31:0] y;
  logic [31:0] y_q;
  logic        sel_err;
  logic [7:0]  err_cnt;

  int compared = 0;
  int mismatched = 0;

  mux3 #(.WIDTH(32), .CNT_W(8)) dut (
    .clk     (clk),
    .reset   (reset),
    .d0      (d0),
    .d1      (d1),
    .d2      (d2),
    .sel     (sel),
    .y       (y),
    .y_q     (y_q),
    .sel_err (sel_err),
    .err_cnt (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input string tag, input logic [1:0] s,
                      input logic [31:0] ey, input logic ee);
    @(negedge clk);
    sel = s;
    #1;
    chk({tag, "_y"}, y, ey);
    chk({tag, "_sel_err"}, {31'b0, sel_err}, {31'b0, ee});
    @(posedge clk);
    #1;
    chk({tag, "_y_q"}, y_q, ey);
  endtask

  initial begin
    reset = 1'b1;
    sel   = 2'b00;
    d0    = 32'h37b83cf9;
    d1    = 32'hf3dc719f;
    d2    = 32'he75b262d;
    @(posedge clk);
    #1;
    chk("rst_y_q", y_q, 32'h0);
    chk("rst_err_cnt", {24'b0, err_cnt}, 32'h0);
    chk("rst_y", y, 32'h37b83cf9);
    chk("rst_sel_err", {31'b0, sel_err}, 32'h0);
    @(negedge clk);
    reset = 1'b0;

    step("v1_s0", 2'b00, 32'h37b83cf9, 1'b0);
    step("v1_s1", 2'b01, 32'hf3dc719f, 1'b0);
    step("v1_s2", 2'b10, 32'he75b262d, 1'b0);
    step("v1_s3", 2'b11, 32'h00000000, 1'b1);
    chk("v1_err_cnt", {24'b0, err_cnt}, 32'd1);

    d0 = 32'h6420271d;
    d1 = 32'h030ceb69;
    d2 = 32'hf707ce7e;
    step("v2_s0", 2'b00, 32'h6420271d, 1'b0);
    chk("v2_err_hold", {24'b0, err_cnt}, 32'd1);
    step("v2_s1", 2'b01, 32'h030ceb69, 1'b0);
    step("v2_s2", 2'b10, 32'hf707ce7e, 1'b0);
    step("v2_s3", 2'b11, 32'h00000000, 1'b1);
    chk("v2_err_cnt", {24'b0, err_cnt}, 32'd2);

    d0 = 32'h5cc0bf9c;
    d1 = 32'hc6da743d;
    d2 = 32'h75c816b7;
    step("v3_s0", 2'b00, 32'h5cc0bf9c, 1'b0);
    step("v3_s1", 2'b01, 32'hc6da743d, 1'b0);
    step("v3_s2", 2'b10, 32'h75c816b7, 1'b0);
    step("v3_s3", 2'b11, 32'h00000000, 1'b1);
    chk("v3_err_cnt", {24'b0, err_cnt}, 32'd3);

    // sel stays 11: 252 more edges reach 255, then 48 more must hold
    repeat (251) @(posedge clk);
    #1;
    chk("sat_254", {24'b0, err_cnt}, 32'd254);
    @(posedge clk);
    #1;
    chk("sat_255", {24'b0, err_cnt}, 32'd255);
    repeat (48) @(posedge clk);
    #1;
    chk("sat_hold", {24'b0, err_cnt}, 32'd255);

    step("pre_rst", 2'b00, 32'h5cc0bf9c, 1'b0);
    chk("pre_rst_err", {24'b0, err_cnt}, 32'd255);

    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_y_q", y_q, 32'h0);
    chk("arst_err_cnt", {24'b0, err_cnt}, 32'h0);
    sel = 2'b01;
    #1;
    chk("arst_y_d1", y, 32'hc6da743d);
    sel = 2'b11;
    #1;
    chk("arst_y_s3", y, 32'h0);
    chk("arst_sel_err", {31'b0, sel_err}, 32'h1);
    @(posedge clk);
    #1;
    chk("arst_edge_err", {24'b0, err_cnt}, 32'h0);
    chk("arst_edge_y_q", y_q, 32'h0);
    @(negedge clk);
    sel = 2'b10;
    reset = 1'b0;
    #1;
    chk("rel_y_q", y_q, 32'h0);
    @(posedge clk);
    #1;
    chk("rel_edge_y_q", y_q, 32'h75c816b7);
    chk("rel_edge_err", {24'b0, err_cnt}, 32'h0);

    step("d1_base", 2'b01, 32'hc6da743d, 1'b0);
    @(negedge clk);
    d1 = 32'h0badf00d;
    #1;
    chk("d1_live_y", y, 32'h0badf00d);
    chk("d1_old_y_q", y_q, 32'hc6da743d);
    @(posedge clk);
    #1;
    chk("d1_new_y_q", y_q, 32'h0badf00d);
    chk("end_err", {24'b0, err_cnt}, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
